regread_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a single shared 64-bit register-file read port (the 32:1 × 64-bit read multiplexer). Up to `NREQ` requesters (decode stage, store-data path, debug/trace port, etc.) issue 5-bit register reads over a valid/ready handshake. The block drives the mux `select`, waits one full cycle for the gate-level mux to settle, captures the 64-bit result, and returns it tagged with the requester ID. It sits between the register file's read mux and the pipeline stages that share that port.

---
 rtl/regread_arbiter_if.sv | 27 ++
 rtl/regread_arbiter.sv | 99 +++++++++
 tb/tb_regread_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/regread_arbiter_if.sv
// Handshake bundle between the register-file read port arbiter, its
// requesters, the 32:1 x 64-bit read mux, and the response consumer.
// The slave modport is the arbiter's view; master is the environment's.
interface regread_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][4:0] req_addr;
  logic [NREQ-1:0]      req_ready;
  logic [4:0]           rf_select;
  logic [63:0]          rf_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [63:0]          rsp_data;

  modport slave (
    input  req_valid, req_addr, rf_data, rsp_ready,
    output req_ready, rf_select, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_addr, rf_data, rsp_ready,
    input  req_ready, rf_select, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/regread_arbiter.sv
// Round-robin arbiter/sequencer for the shared 64-bit register-file read
// port. One grant drives rf_select, a full cycle is left for the gate-level
// mux to settle, then the value is captured and returned tagged with the
// requester ID. Optional macro REGREAD_XZR_EN: register 31 reads as zero.
module regread_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic              clk,
  input logic              reset,
  regread_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win;
  logic            found;
  logic            grant_en;
  logic            grant;
  logic [63:0]     rd_val;

  // Round-robin search starting one past the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // A grant may only issue from IDLE, or from RESP once the current
  // response is being accepted; never while reset is held.
  always_comb begin
    grant_en      = (state == S_IDLE) || ((state == S_RESP) && bus.rsp_ready);
    grant         = grant_en && found && !reset;
    bus.req_ready = grant ? (NREQ'(1) << win) : '0;
  end

  // Value captured from the mux; XZR build forces register 31 to zero.
  always_comb begin
`ifdef REGREAD_XZR_EN
    rd_val = (bus.rf_select == 5'd31) ? 64'h0 : bus.rf_data;
`else
    rd_val = bus.rf_data;
`endif
  end

  // Sequencer: grant -> settle/capture -> hold response until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ptr           <= IDW'(NREQ - 1);
      bus.rf_select <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            bus.rf_select <= bus.req_addr[win];
            bus.rsp_id    <= win;
            ptr           <= win;
            state         <= S_READ;
          end
        end
        S_READ: begin
          bus.rsp_data  <= rd_val;
          bus.rsp_valid <= 1'b1;
          state         <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (grant) begin
              bus.rf_select <= bus.req_addr[win];
              bus.rsp_id    <= win;
              ptr           <= win;
              state         <= S_READ;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regread_arbiter.sv
// Directed bench for regread_arbiter: a scoreboard queue is filled at each
// observed grant and drained at each accepted response.
module tb_regread_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ones_mode = 1'b0;
  logic one_shot  = 1'b0;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  int   gq[$];

  regread_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  regread_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Read mux stand-in: value encodes the selected register.
  assign bus.rf_data = ones_mode ? 64'hFFFF_FFFF_FFFF_FFFF
                                 : {32'hDEAD_BEEF, 27'h0, bus.rf_select};

  function automatic logic [63:0] model(input logic [4:0] a, input logic ones);
    logic [63:0] m;
    m = ones ? 64'hFFFF_FFFF_FFFF_FFFF : {32'hDEAD_BEEF, 27'h0, a};
`ifdef REGREAD_XZR_EN
    if (a == 5'd31) m = 64'h0;
`endif
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: evaluate handshakes at the negedge before the edge, then
  // advance to just past the rising edge.
  task automatic cyc();
    exp_t e;
    int   g;
    @(negedge clk);
    g = -1;
    if (reset) begin
      sb.delete();
    end else begin
      chk("onehot", 64'($onehot0(bus.req_ready)), 64'd1);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'(bus.rsp_id), 64'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          chk("rsp_data", bus.rsp_data, e.data);
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) g = i;
      if (g >= 0) begin
        e.id   = IDW'(g);
        e.data = model(bus.req_addr[g], ones_mode);
        sb.push_back(e);
        gq.push_back(g);
      end
    end
    @(posedge clk);
    #1;
    if (one_shot && g >= 0) bus.req_valid[g] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    logic [IDW-1:0] hid;
    logic [63:0]    hdata;

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) bus.req_addr[i] = 5'(10 + i);

    // Reset state, with every requester asserting valid.
    bus.req_valid = 4'b1111;
    cyc();
    cyc();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rf_select", 64'(bus.rf_select), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    bus.req_valid = '0;
    reset = 1'b0;
    cyc();

    // Single request, latency of two edges.
    one_shot = 1'b1;
    bus.req_addr[0] = 5'd5;
    bus.req_valid = 4'b0001;
    #1;
    chk("single_grant", 64'(bus.req_ready), 64'b0001);
    cyc();
    chk("single_sel", 64'(bus.rf_select), 64'd5);
    chk("single_nvalid", 64'(bus.rsp_valid), 64'd0);
    cyc();
    chk("single_valid", 64'(bus.rsp_valid), 64'd1);
    chk("single_id", 64'(bus.rsp_id), 64'd0);
    chk("single_data", bus.rsp_data, 64'hDEAD_BEEF_0000_0005);
    cyc();
    chk("single_idle", 64'(bus.rsp_valid), 64'd0);

    // All four requesting continuously: 0,1,2,3,0 at one per two cycles.
    do_reset();
    one_shot = 1'b0;
    gq.delete();
    for (int i = 0; i < NREQ; i++) bus.req_addr[i] = 5'(20 + i);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 9; c++) cyc();
    bus.req_valid = '0;
    chk("rr_count", 64'(gq.size()), 64'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      chk("rr_order", 64'(gq[i]), 64'(i % NREQ));
    for (int c = 0; c < 3; c++) cyc();

    // Backpressure in RESP, then same-cycle grant on release.
    do_reset();
    one_shot = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0110;
    cyc();
    cyc();
    chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("bp_first_id", 64'(bus.rsp_id), 64'd1);
    hid   = bus.rsp_id;
    hdata = bus.rsp_data;
    for (int c = 0; c < 5; c++) begin
      chk("bp_no_grant", 64'(bus.req_ready), 64'd0);
      cyc();
      chk("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_hold_id", 64'(bus.rsp_id), 64'(hid));
      chk("bp_hold_data", bus.rsp_data, hdata);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", 64'(bus.req_ready), 64'b0100);
    for (int c = 0; c < 4; c++) cyc();

    // Requester 2 withdraws before its turn; 1 then 3 are served.
    do_reset();
    gq.delete();
    bus.req_valid = 4'b0001;
    cyc();
    bus.req_valid = 4'b1110;
    cyc();
    cyc();
    bus.req_valid[2] = 1'b0;
    for (int c = 0; c < 5; c++) cyc();
    chk("drop_count", 64'(gq.size()), 64'd3);
    if (gq.size() == 3) begin
      chk("drop_g0", 64'(gq[0]), 64'd0);
      chk("drop_g1", 64'(gq[1]), 64'd1);
      chk("drop_g2", 64'(gq[2]), 64'd3);
    end

    // Reset during READ abandons the read; pointer restarts at requester 0.
    do_reset();
    bus.req_valid = 4'b0100;
    cyc();
    chk("abort_sel", 64'(bus.rf_select), 64'(bus.req_addr[2]));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("abort_valid", 64'(bus.rsp_valid), 64'd0);
    cyc();
    cyc();
    chk("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
    bus.req_valid = 4'b1111;
    #1;
    chk("abort_first_grant", 64'(bus.req_ready), 64'b0001);
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 4; c++) cyc();

    // Register 31 with an all-ones mux output.
    ones_mode = 1'b1;
    bus.req_addr[0] = 5'd31;
    bus.req_valid = 4'b0001;
    cyc();
    cyc();
`ifdef REGREAD_XZR_EN
    chk("xzr_data", bus.rsp_data, 64'h0);
`else
    chk("r31_data", bus.rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    cyc();
    ones_mode = 1'b0;
    cyc();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
